piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in serial-out transmitter. It takes a DATA_W-bit word through a valid/ready load handshake and shifts it out one bit at a time. Each bit is held for CLKS_PER_BIT enabled clock cycles. It is the read-out counterpart of the enabled storage registers in the sequential-logic lab set: a register word goes in, and a timed serial stream comes out for downstream serial receivers and shift-register labs.

Parameters:
DATA_W, 8, word width in bits (>=2)
CLKS_PER_BIT, 4, enabled clock cycles each bit is held on ser_out (>=1)
MSB_FIRST, 1, 1 = bit DATA_W-1 sent first; 0 = bit 0 sent first

Ports:
sys_clk  input  1  system clock; all state updates on rising edge
sys_rst  input  1  synchronous, active-high reset; sampled on sys_clk rising edge
shift_en  input  1  global advance enable; 0 freezes all internal state
load_valid  input  1  upstream has a word on load_data
load_data  input  DATA_W  word to transmit; sampled only on handshake
load_ready  output  1  block can accept a word (combinational)
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out carries a frame bit
busy  output  1  frame in progress (state SHIFT)
done  output  1  one-cycle pulse after the last bit period completes

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset dominates everything. At the next edge with sys_rst=1: state=IDLE, shreg=0, bit_cnt=0, div_cnt=0, ser_out=0, ser_valid=0, busy=0, done=0. Any handshake in that cycle is ignored.
- States: IDLE, SHIFT.
- load_ready = (state==IDLE) & shift_en & ~sys_rst. Accept occurs when load_valid & load_ready at a rising edge.
- IDLE:
  - ser_out=0, ser_valid=0, busy=0.
  - On accept: shreg<=load_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- SHIFT:
  - busy=1, ser_valid=1.
  - ser_out = shreg[DATA_W-1] if MSB_FIRST, else shreg[0].
  - ser_out, ser_valid and busy are registered, so they change only on edges.
  - load_ready=0; load_valid and load_data are ignored.
- Per edge in SHIFT with shift_en=1:
  - If div_cnt<CLKS_PER_BIT-1: div_cnt++.
  - Else: div_cnt<=0.
    - If bit_cnt==DATA_W-1: state<=IDLE, done<=1.
    - Else: bit_cnt++ and shreg shifts by one toward the output end, zero-filling.
- shift_en=0: shreg, bit_cnt, div_cnt and state hold; ser_out and ser_valid hold their values; no accept in IDLE. The bit being held is stretched by the number of disabled cycles.
- done is 1 only in the first IDLE cycle after a frame, and is 0 otherwise. It is not asserted for a frame aborted by reset.
- Latency: accept at edge k. ser_valid=1 for cycles k+1 through k+DATA_W*CLKS_PER_BIT, with no shift_en stalls. done=1 in the following cycle.
- Back-to-back frames: load_ready rises in the done cycle. With load_valid held high, exactly one ser_valid=0 cycle separates frames.
- Counter widths: bit_cnt is clog2(DATA_W) bits; div_cnt is max(1, clog2(CLKS_PER_BIT)) bits. Neither counter wraps past its terminal value.
- CLKS_PER_BIT=1: a new bit is presented every enabled cycle.
- Changing load_data after accept has no effect on the frame in flight.

Test Plan:
1. Defaults changed to DATA_W=8, CLKS_PER_BIT=2, MSB_FIRST=1; load 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1, each bit held 2 cycles. ser_valid=1 for exactly 16 cycles. done pulses once at accept+17. load_ready=0 throughout.
2. MSB_FIRST=0, load 8'h1E -> ser_out 0,1,1,1,1,0,0,0. Frame length and done timing as in scenario 1.
3. During bit 3 of an 8'hA5 frame, drop shift_en for 3 cycles -> bit 3 held 5 cycles; other bits unchanged; ser_valid high 19 cycles; done at accept+20. Raise load_valid in IDLE with shift_en=0 -> no accept.
4. Assert sys_rst for 1 cycle during bit 4 -> the next cycle shows ser_out=0, ser_valid=0, busy=0, done=0, with no done pulse afterwards. A new load of 8'h3C then transmits correctly.
5. Hold load_valid=1 with data 8'hF0 then 8'h0F -> the two frames are separated by exactly one ser_valid=0 cycle. The second load is accepted in the done cycle.
6. While in SHIFT, pulse load_valid with 8'hFF -> ignored. The current frame bits are unchanged and no extra frame is sent.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter. A word accepted over a valid/ready
// handshake is shifted out one bit at a time, each bit held for
// CLKS_PER_BIT enabled cycles. shift_en freezes all progress when low.
module piso_shift_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              shift_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BitCntW = $clog2(DATA_W);
    localparam int unsigned DivCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_W - 1);
    localparam logic [DivCntW-1:0] DivLast = DivCntW'(CLKS_PER_BIT - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [BitCntW-1:0]  bit_cnt_q;
    logic [DivCntW-1:0]  div_cnt_q;

    logic [DATA_W-1:0]   shreg_shifted;
    logic                shifted_bit;
    logic                load_bit;

    // Next word after one shift toward the output end, and the bit that lands there.
    always_comb begin
        shreg_shifted = '0;
        shifted_bit   = 1'b0;
        load_bit      = 1'b0;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[DATA_W-2:0], 1'b0};
            shifted_bit   = shreg_q[DATA_W-2];
            load_bit      = load_data[DATA_W-1];
        end else begin
            shreg_shifted = {1'b0, shreg_q[DATA_W-1:1]};
            shifted_bit   = shreg_q[1];
            load_bit      = load_data[0];
        end
    end

    assign load_ready = (state_q == StIdle) & shift_en & ~sys_rst;

    // Frame FSM with registered serial outputs; done clears on any edge it is not set.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift_en) begin
                unique case (state_q)
                    StIdle: begin
                        if (load_valid) begin
                            shreg_q   <= load_data;
                            bit_cnt_q <= '0;
                            div_cnt_q <= '0;
                            state_q   <= StShift;
                            ser_out   <= load_bit;
                            ser_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    StShift: begin
                        if (div_cnt_q != DivLast) begin
                            div_cnt_q <= div_cnt_q + DivCntW'(1);
                        end else begin
                            div_cnt_q <= '0;
                            if (bit_cnt_q == BitLast) begin
                                state_q   <= StIdle;
                                done      <= 1'b1;
                                ser_out   <= 1'b0;
                                ser_valid <= 1'b0;
                                busy      <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                                shreg_q   <= shreg_shifted;
                                ser_out   <= shifted_bit;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: an MSB-first and an LSB-first instance
// share stimulus; a bit-queue scoreboard predicts every output cycle.
module tb_piso_shift_tx;

    localparam int W = 8;
    localparam int C = 2;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         shift_en;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic m_ready, m_out, m_valid, m_busy, m_done;
    logic l_ready, l_out, l_valid, l_busy, l_done;

    int n_checks = 0;
    int n_fail   = 0;

    bit qm[$];
    bit ql[$];
    bit exp_shift = 1'b0;
    bit exp_done  = 1'b0;
    int since       = 0;
    int valid_cnt   = 0;
    int done_since  = -1;

    piso_shift_tx #(.DATA_W(W), .CLKS_PER_BIT(C), .MSB_FIRST(1'b1)) dut_msb (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .shift_en   (shift_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (m_ready),
        .ser_out    (m_out),
        .ser_valid  (m_valid),
        .busy       (m_busy),
        .done       (m_done)
    );

    piso_shift_tx #(.DATA_W(W), .CLKS_PER_BIT(C), .MSB_FIRST(1'b0)) dut_lsb (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .shift_en   (shift_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (l_ready),
        .ser_out    (l_out),
        .ser_valid  (l_valid),
        .busy       (l_busy),
        .done       (l_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one edge using current inputs, then clock the DUTs
    // and compare every output at the following falling edge.
    task automatic tick();
        bit eo_m;
        bit eo_l;
        if (sys_rst) begin
            exp_shift = 1'b0;
            exp_done  = 1'b0;
            qm.delete();
            ql.delete();
        end else begin
            exp_done = 1'b0;
            if (shift_en) begin
                if (!exp_shift) begin
                    if (load_valid) begin
                        for (int i = 0; i < W; i++) begin
                            for (int c = 0; c < C; c++) begin
                                qm.push_back(load_data[W-1-i]);
                                ql.push_back(load_data[i]);
                            end
                        end
                        exp_shift = 1'b1;
                        since     = 0;
                        valid_cnt = 0;
                        done_since = -1;
                    end
                end else begin
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                    if (qm.size() == 0) begin
                        exp_shift = 1'b0;
                        exp_done  = 1'b1;
                    end
                end
            end
        end
        since++;
        @(posedge sys_clk);
        @(negedge sys_clk);
        eo_m = exp_shift ? qm[0] : 1'b0;
        eo_l = exp_shift ? ql[0] : 1'b0;
        chk("msb_ser_out", m_out, eo_m);
        chk("msb_ser_valid", m_valid, exp_shift);
        chk("msb_busy", m_busy, exp_shift);
        chk("msb_done", m_done, exp_done);
        chk("msb_load_ready", m_ready, !exp_shift && shift_en && !sys_rst);
        chk("lsb_ser_out", l_out, eo_l);
        chk("lsb_ser_valid", l_valid, exp_shift);
        chk("lsb_busy", l_busy, exp_shift);
        chk("lsb_done", l_done, exp_done);
        chk("lsb_load_ready", l_ready, !exp_shift && shift_en && !sys_rst);
        if (m_valid) valid_cnt++;
        if (m_done) done_since = since;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (m_done) break;
        end
        chk(tag, m_done, 1'b1);
    endtask

    initial begin
        sys_rst    = 1'b1;
        shift_en   = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        tick();
        tick();
        chk("rst_ser_out", m_out, 1'b0);
        chk("rst_ser_valid", m_valid, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        sys_rst = 1'b0;
        tick();
        chk("idle_load_ready", m_ready, 1'b1);

        // Scenario 1/2: plain frame; LSB instance covers bit-0-first ordering.
        load_data  = 8'hA5;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        load_data  = 8'h00;
        wait_done("s1_done_seen", 40);
        chk("s1_done_at", done_since, 17);
        chk("s1_valid_cycles", valid_cnt, 16);
        tick();

        load_data  = 8'h1E;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        load_data  = 8'hC3;
        wait_done("s2_done_seen", 40);
        chk("s2_done_at", done_since, 17);
        chk("s2_valid_cycles", valid_cnt, 16);
        tick();

        // Scenario 3: stall three cycles during bit 3.
        load_data  = 8'hA5;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (7) tick();
        shift_en = 1'b0;
        repeat (3) tick();
        shift_en = 1'b1;
        wait_done("s3_done_seen", 40);
        chk("s3_done_at", done_since, 20);
        chk("s3_valid_cycles", valid_cnt, 19);
        shift_en   = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h55;
        repeat (3) tick();
        chk("s3_no_accept", m_busy, 1'b0);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        tick();

        // Scenario 4: reset during bit 4 aborts with no done pulse.
        load_data  = 8'hA5;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (9) tick();
        sys_rst = 1'b1;
        tick();
        chk("s4_ser_out", m_out, 1'b0);
        chk("s4_ser_valid", m_valid, 1'b0);
        chk("s4_busy", m_busy, 1'b0);
        chk("s4_done", m_done, 1'b0);
        sys_rst = 1'b0;
        repeat (20) tick();
        load_data  = 8'h3C;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        wait_done("s4_done_seen", 40);
        chk("s4_done_at", done_since, 17);
        tick();

        // Scenario 5: back-to-back frames with load_valid held.
        load_data  = 8'hF0;
        load_valid = 1'b1;
        tick();
        load_data = 8'h0F;
        wait_done("s5a_done_seen", 40);
        chk("s5_gap_cycle", m_valid, 1'b0);
        tick();
        chk("s5_reaccept", m_valid, 1'b1);
        load_valid = 1'b0;
        wait_done("s5b_done_seen", 40);
        chk("s5b_done_at", done_since, 17);
        tick();

        // Scenario 6: load pulse while shifting is ignored.
        load_data  = 8'h96;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        load_valid = 1'b1;
        load_data  = 8'hFF;
        tick();
        load_valid = 1'b0;
        wait_done("s6_done_seen", 40);
        chk("s6_done_at", done_since, 17);
        repeat (5) tick();
        chk("s6_no_extra", m_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
